// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the RAM request controller.
// Used by the controller top and its response FIFO.
package ram_ctrl_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ctrl_state_t;

  // Bits needed to hold a count of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ram_req_ctrl_if.sv
// Request and response handshake bundle between a client and ram_req_ctrl.
// The controller uses the slave modport; the client uses the master modport.
interface ram_req_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_rsp_fifo.sv
// Flop-based response FIFO holding read data until the downstream takes it.
// head reads as zero while the FIFO is empty.
module ram_rsp_fifo
  import ram_ctrl_pkg::*;
#(
  parameter int  DEPTH      = 3,
  parameter int  DATA_WIDTH = 8,
  localparam int CW         = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [CW-1:0]         count,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= bump(wr_ptr);
      if (do_pop) rd_ptr <= bump(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !do_pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/ram_req_ctrl.sv
// Valid/ready front-end for a single-port synchronous RAM with in-order buffered reads.
// Define RAM_CLEAR_EN to zero the whole RAM after every reset before accepting requests.
module ram_req_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RSP_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_req_ctrl_if.slave         host,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  init_done
);

  localparam int CW = cnt_width(RSP_DEPTH);

  ctrl_state_t           state;
  ctrl_state_t           state_nxt;
  logic                  rd_inflight;
  logic                  rd_accept;
  logic                  req_ok;
  logic [CW-1:0]         rsp_count;
  logic [CW:0]           credit_used;
  logic [DATA_WIDTH-1:0] rsp_head;
  logic                  rsp_pop;
`ifdef RAM_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_cnt;
`endif

  // NOTE: every flop in a clocked block is assigned with <= so all of them sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef RAM_CLEAR_EN
      state   <= CLEAR;
      clr_cnt <= '0;
`else
      state   <= RUN;
`endif
      rd_inflight <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_inflight <= rd_accept;
`ifdef RAM_CLEAR_EN
      if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
`endif
    end
  end

  // Reads accepted but not yet drained; a new request needs a free slot.
  assign credit_used = {1'b0, rsp_count} + {{CW{1'b0}}, rd_inflight};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = host.req_addr;
    ram_din   = host.req_wdata;
    req_ok    = 1'b0;
    rd_accept = 1'b0;
    case (state)
`ifdef RAM_CLEAR_EN
      CLEAR: begin
        ram_we   = rst_n;
        ram_addr = clr_cnt;
        ram_din  = '0;
        if (clr_cnt == '1) state_nxt = RUN;
      end
`endif
      RUN: begin
        req_ok    = rst_n && (credit_used < (CW + 1)'(RSP_DEPTH));
        ram_we    = host.req_valid && req_ok && host.req_we;
        rd_accept = host.req_valid && req_ok && !host.req_we;
      end
      default: ;
    endcase
  end

  assign host.req_ready = req_ok;
  assign init_done      = rst_n && (state == RUN);

  // Data is captured only in the cycle after a read accept, so idle reads never leak in.
  ram_rsp_fifo #(
    .DEPTH      (RSP_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_inflight),
    .pop   (rsp_pop),
    .din   (ram_dout),
    .count (rsp_count),
    .head  (rsp_head)
  );

  assign host.rsp_valid = rst_n && (rsp_count != '0);
  assign host.rsp_rdata = host.rsp_valid ? rsp_head : '0;
  assign rsp_pop        = host.rsp_valid && host.rsp_ready;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Self-checking bench for ram_req_ctrl with a behavioural single-port RAM and a queue-based reference.
// Covers both builds; with RAM_CLEAR_EN defined the clear sequence is checked as well.
module tb_ram_req_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          init_done;

  always #5 clk = ~clk;

  ram_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) host ();

  ram_req_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host      (host),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .init_done (init_done)
  );

  // Single-port RAM: write when we, else registered read; dout held across writes.
  logic [DW-1:0] ram_mem [1 << AW];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    else        ram_dout          <= ram_mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: RAM contents as seen by accepted requests, plus the reads still owed.
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } rd_t;

  rd_t           pend[$];
  logic [DW-1:0] model_mem [1 << AW];
  int            cyc   = 0;
  bit            sb_on = 1'b0;
  bit            exp_rv;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
    end else begin
      if (sb_on) begin
        check("sb_req_ready", host.req_ready, pend.size() < DEPTH);
        exp_rv = (pend.size() != 0) && (cyc - pend[0].cyc >= 2);
        check("sb_rsp_valid", host.rsp_valid, exp_rv);
        if (exp_rv) check("sb_rsp_rdata", host.rsp_rdata, pend[0].data);
      end
      if (host.rsp_valid && host.rsp_ready && pend.size() != 0) pend.pop_front();
      if (host.req_valid && host.req_ready) begin
        if (host.req_we) model_mem[host.req_addr] = host.req_wdata;
        else             pend.push_back('{model_mem[host.req_addr], cyc});
      end
    end
    cyc++;
  end

  typedef struct {
    bit            v;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    bit            rr;
    bit            e_ready;
    bit            e_rv;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tbl [17];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    host.req_valid = 1'b0;
    host.req_we    = 1'b0;
  endtask

  task automatic issue(input string name, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd);
    bit ok = 1'b0;
    host.req_valid = 1'b1;
    host.req_we    = we;
    host.req_addr  = addr;
    host.req_wdata = wd;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = host.req_ready;
      next_cycle();
    end
    idle();
    check({name, "_accepted"}, ok, 1'b1);
  endtask

  task automatic get_rsp(input string name, input logic [DW-1:0] exp);
    bit got = 1'b0;
    host.rsp_ready = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (host.rsp_valid) begin
        got = 1'b1;
        check(name, host.rsp_rdata, exp);
      end
      next_cycle();
    end
    check({name, "_seen"}, got, 1'b1);
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    check({name, "_req_ready"}, host.req_ready, 1'b0);
    check({name, "_rsp_valid"}, host.rsp_valid, 1'b0);
    check({name, "_ram_we"},    ram_we,         1'b0);
    check({name, "_init_done"}, init_done,      1'b0);
  endtask

  task automatic after_release();
`ifdef RAM_CLEAR_EN
    foreach (model_mem[i]) model_mem[i] = '0;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    int            acc;
    int            k;
    bit            got;

    foreach (ram_mem[i]) begin
`ifdef RAM_CLEAR_EN
      ram_mem[i]   = 8'hEE;
      model_mem[i] = 8'hEE;
`else
      ram_mem[i]   = 8'h00;
      model_mem[i] = 8'h00;
`endif
    end
    ram_dout       = '0;
    host.req_valid = 1'b0;
    host.req_we    = 1'b0;
    host.req_addr  = '0;
    host.req_wdata = '0;
    host.rsp_ready = 1'b0;

    // Test 1: reset state, optional clear sweep, then a read of a cleared word.
    repeat (2) next_cycle();
    check_reset_outputs("t1_reset");
    next_cycle();
    rst_n = 1'b1;
    after_release();
`ifdef RAM_CLEAR_EN
    for (int i = 0; i < (1 << AW); i++) begin
      @(negedge clk);
      check("t1_clr_we",        ram_we,         1'b1);
      check("t1_clr_addr",      ram_addr,       i);
      check("t1_clr_din",       ram_din,        8'h00);
      check("t1_clr_req_ready", host.req_ready, 1'b0);
      check("t1_clr_init_done", init_done,      1'b0);
      next_cycle();
    end
`endif
    @(negedge clk);
    check("t1_init_done", init_done,      1'b1);
    check("t1_req_ready", host.req_ready, 1'b1);
    next_cycle();
    issue("t1_rd5", 1'b0, 4'd5, 8'h00);
    get_rsp("t1_rsp5", 8'h00);
    host.rsp_ready = 1'b0;

    // Table: write-then-read latency, credit stall, in-order drain, read-before-write.
    tbl[0]  = '{1'b1, 1'b1, 4'd3, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 4'd4, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 4'd4, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5};
    tbl[4]  = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5};
    tbl[5]  = '{1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5};
    tbl[6]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5};
    tbl[7]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C};
    tbl[8]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5};
    tbl[9]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[11] = '{1'b1, 1'b1, 4'd5, 8'h77, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00};
    tbl[13] = '{1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77};
    tbl[16] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    foreach (tbl[i]) begin
      host.req_valid = tbl[i].v;
      host.req_we    = tbl[i].we;
      host.req_addr  = tbl[i].addr;
      host.req_wdata = tbl[i].wd;
      host.rsp_ready = tbl[i].rr;
      @(negedge clk);
      check($sformatf("tbl%0d_req_ready", i), host.req_ready, tbl[i].e_ready);
      check($sformatf("tbl%0d_rsp_valid", i), host.rsp_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) check($sformatf("tbl%0d_rsp_rdata", i), host.rsp_rdata, tbl[i].e_rd);
      next_cycle();
    end
    idle();

    // Test 3: back-to-back writes then reads at full rate, responses without gaps.
    host.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      host.req_valid = 1'b1;
      host.req_we    = 1'b1;
      host.req_addr  = AW'(i);
      host.req_wdata = DW'(i) ^ 8'h5A;
      @(negedge clk);
      check("t3_wr_ready", host.req_ready, 1'b1);
      next_cycle();
    end
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        host.req_valid = 1'b1;
        host.req_we    = 1'b0;
        host.req_addr  = AW'(c);
      end else begin
        idle();
      end
      @(negedge clk);
      if (c < 16) check("t3_rd_ready", host.req_ready, 1'b1);
      if (c >= 2) begin
        d = DW'(c - 2) ^ 8'h5A;
        check("t3_rsp_valid", host.rsp_valid, 1'b1);
        check("t3_rsp_rdata", host.rsp_rdata, d);
      end else begin
        check("t3_rsp_early", host.rsp_valid, 1'b0);
      end
      next_cycle();
    end
    idle();

    // Test 4: backpressure stops acceptance after exactly DEPTH reads.
    host.rsp_ready = 1'b0;
    acc = 0;
    k   = 0;
    for (int c = 0; c < 6; c++) begin
      host.req_valid = 1'b1;
      host.req_we    = 1'b0;
      host.req_addr  = AW'(k);
      @(negedge clk);
      got = host.req_ready;
      next_cycle();
      if (got) begin
        acc++;
        k++;
      end
    end
    idle();
    check("t4_accepts", acc, DEPTH);
    @(negedge clk);
    check("t4_ready_blocked", host.req_ready, 1'b0);
    next_cycle();
    for (int j = 0; j < DEPTH; j++) get_rsp($sformatf("t4_drain%0d", j), DW'(j) ^ 8'h5A);
    @(negedge clk);
    check("t4_ready_back", host.req_ready, 1'b1);
    next_cycle();

    // Test 5: idle cycles reading another address do not disturb a buffered response.
    issue("t5_wr7", 1'b1, 4'd7, 8'h11);
    issue("t5_wr8", 1'b1, 4'd8, 8'h22);
    host.rsp_ready = 1'b0;
    issue("t5_rd7", 1'b0, 4'd7, 8'h00);
    host.req_addr = 4'd8;
    repeat (4) next_cycle();
    @(negedge clk);
    check("t5_rsp_valid", host.rsp_valid, 1'b1);
    check("t5_rsp_rdata", host.rsp_rdata, 8'h11);
    next_cycle();
    get_rsp("t5_pop", 8'h11);

    // Test 6: reset with buffered responses discards them.
    host.rsp_ready = 1'b0;
    issue("t6_rd7", 1'b0, 4'd7, 8'h00);
    issue("t6_rd8", 1'b0, 4'd8, 8'h00);
    repeat (2) next_cycle();
    @(negedge clk);
    check("t6_buffered", host.rsp_valid, 1'b1);
    next_cycle();
    rst_n = 1'b0;
    check_reset_outputs("t6_reset");
    next_cycle();
    rst_n          = 1'b1;
    host.rsp_ready = 1'b1;
    after_release();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t6_no_stale", host.rsp_valid, 1'b0);
      next_cycle();
    end
    @(negedge clk);
    check("t6_init_done", init_done, 1'b1);
    next_cycle();

    // Randomized traffic against the reference queue.
    sb_on = 1'b1;
    for (int c = 0; c < 600; c++) begin
      host.req_valid = 1'($urandom_range(0, 1));
      host.req_we    = ($urandom_range(0, 3) == 0);
      host.req_addr  = AW'($urandom_range(0, (1 << AW) - 1));
      host.req_wdata = DW'($urandom);
      host.rsp_ready = ($urandom_range(0, 9) < 7);
      next_cycle();
    end
    idle();
    host.rsp_ready = 1'b1;
    repeat (10) next_cycle();
    sb_on = 1'b0;
    check("sb_drained", pend.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
